// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencing controller for the 8-bit LED counter.
// Debounces the run/clear buttons, synchronizes the speed and direction
// switches, divides sys_clk down to step ticks and runs the
// IDLE/RUN/PAUSE/TURN state machine that strobes the counter.
// Optional build macro: LED_SEQ_BOUNCE_EN selects ping-pong mode. In that
// mode the counter reverses at 8'hFF / 8'h00 and sw_ud is ignored in RUN.
module led_seq_ctrl #(
  parameter int DEB_CYCLES = 2_000_000,
  parameter int SLOW_DIV   = 100_000_000,
  parameter int FAST_DIV   = 20_000_000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       sw_ud,
  input  logic       sw_sf,
  input  logic [7:0] cnt_val,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic [1:0] state
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Synchronizer stages, bit order {btn_run, btn_clr, sw_ud, sw_sf}
  logic [3:0] sync_p0, sync_p1;
  logic [1:0] btn_s;
  logic       ud_s, sf_s;

  // Debounce state per button, index 1 = run, 0 = clr
  logic [1:0][DEB_W-1:0] deb_cnt;
  logic [1:0]            deb_lvl, deb_prev, press;
  logic                  run_press, clr_press;

  logic [27:0] div_cnt, div_lim;
  logic        counting, wrap;

  logic turn_req, dir_new;
  logic dir_d, en_d, clr_d;

  // ---- stage p0/p1: two-flop synchronizers for every board input
  // Double-register the raw buttons and switches into sys_clk.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {btn_run, btn_clr, sw_ud, sw_sf};
      sync_p1 <= sync_p0;
    end
  end

  assign btn_s = sync_p1[3:2];
  assign ud_s  = sync_p1[1];
  assign sf_s  = sync_p1[0];

  // ---- debounce: the level must differ for DEB_CYCLES straight cycles
  // Any return to the debounced level restarts the count; press is the
  // registered rising edge of the debounced level.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      deb_cnt  <= '0;
      deb_lvl  <= '0;
      deb_prev <= '0;
      press    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          deb_lvl[i] <= btn_s[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
      deb_prev <= deb_lvl;
      press    <= deb_lvl & ~deb_prev;
    end
  end

  assign run_press = press[1];
  assign clr_press = press[0];

  // ---- tick divider: only runs in RUN/TURN, registered wrap pulse
  assign counting = (state_q == RUN) || (state_q == TURN);
  assign div_lim  = sf_s ? 28'(FAST_DIV - 1) : 28'(SLOW_DIV - 1);

  // The >= compare lets a shortened limit wrap at once instead of
  // running past it and around the full 28-bit range.
  always_ff @(posedge sys_clk) begin
    if (reset || !counting) begin
      div_cnt <= '0;
      wrap    <= 1'b0;
    end else if (div_cnt >= div_lim) begin
      div_cnt <= '0;
      wrap    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 28'd1;
      wrap    <= 1'b0;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  // Reverse when the step about to land reaches the end of the range.
  assign turn_req = cnt_en && ((cnt_dir && (cnt_val == 8'hFE)) ||
                               (!cnt_dir && (cnt_val == 8'h01)));
  assign dir_new  = ~cnt_dir;
`else
  assign turn_req = (ud_s != cnt_dir);
  assign dir_new  = ud_s;
  logic unused_cnt_val;
  assign unused_cnt_val = ^cnt_val;
`endif

  // ---- FSM: next state, direction and strobes; clear beats run
  always_comb begin
    state_d = state_q;
    dir_d   = cnt_dir;
    clr_d   = 1'b0;
    en_d    = (state_q == RUN) && wrap && !clr_press;
    if ((state_q == IDLE) || (state_q == PAUSE)) begin
      dir_d = ud_s;
    end
    if (clr_press) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:  if (run_press) state_d = RUN;
        RUN: begin
          if (run_press)     state_d = PAUSE;
          else if (turn_req) state_d = TURN;
        end
        PAUSE: if (run_press) state_d = RUN;
        TURN: begin
          // The wrap that ends TURN issues no step: one skipped period.
          if (run_press) begin
            state_d = PAUSE;
            dir_d   = dir_new;
          end else if (wrap) begin
            state_d = RUN;
            dir_d   = dir_new;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---- output registers
  // State and counter strobes, all registered toward the counter.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_dir <= 1'b1;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_dir <= dir_d;
      cnt_en  <= en_d;
      cnt_clr <= clr_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with DEB_CYCLES=4, SLOW_DIV=10, FAST_DIV=4.
// The stimulus pushes hand-computed output events (cycle, state, cnt_en,
// cnt_clr, cnt_dir); a monitor pops them whenever the DUT outputs change
// or strobe. Cycle N means "after the Nth rising edge".
`timescale 1ns/1ps
module tb_led_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       sw_ud   = 1'b1;
  logic       sw_sf   = 1'b0;
  logic [7:0] cnt_val;
  logic       cnt_en, cnt_dir, cnt_clr;
  logic [1:0] state;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    int         cyc;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       dir;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] st_prev;
  logic       dir_prev;

  // Behavioural LED counter fed by the strobes, starting at 8'hFC.
  logic [7:0] model_cnt = 8'hFC;

  led_seq_ctrl #(
    .DEB_CYCLES(4),
    .SLOW_DIV  (10),
    .FAST_DIV  (4)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .btn_run(btn_run),
    .btn_clr(btn_clr),
    .sw_ud  (sw_ud),
    .sw_sf  (sw_sf),
    .cnt_val(cnt_val),
    .cnt_en (cnt_en),
    .cnt_dir(cnt_dir),
    .cnt_clr(cnt_clr),
    .state  (state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    if (cnt_clr)     model_cnt <= 8'h00;
    else if (cnt_en) model_cnt <= cnt_dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
  end
  assign cnt_val = model_cnt;

`ifdef LED_SEQ_BOUNCE_EN
  bit hit_ff  = 1'b0;
  bit wrapped = 1'b0;
  always @(negedge sys_clk) begin
    if (model_cnt == 8'hFF) hit_ff <= 1'b1;
    if (hit_ff && (model_cnt == 8'h00)) wrapped <= 1'b1;
  end
`endif

  // Monitor: any strobe or change of state/direction is an output event.
  always @(negedge sys_clk) begin
    ev_t e;
    bit  ev;
    if (mon_on) begin
      while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event @%0d: got no event, required st=%0d en=%0b clr=%0b dir=%0b",
                 e.cyc, e.st, e.en, e.clr, e.dir);
      end
      ev = cnt_en || cnt_clr || (state !== st_prev) || (cnt_dir !== dir_prev);
      if (ev) begin
        n_cmp++;
        if ((exp_q.size() == 0) || (exp_q[0].cyc != cyc)) begin
          n_bad++;
          $display("FAIL unexpected_event @%0d: got st=%0d en=%0b clr=%0b dir=%0b, required no event",
                   cyc, state, cnt_en, cnt_clr, cnt_dir);
        end else begin
          e = exp_q.pop_front();
          if ((state !== e.st) || (cnt_en !== e.en) || (cnt_clr !== e.clr) || (cnt_dir !== e.dir)) begin
            n_bad++;
            $display("FAIL event @%0d: got st=%0d en=%0b clr=%0b dir=%0b, required st=%0d en=%0b clr=%0b dir=%0b",
                     cyc, state, cnt_en, cnt_clr, cnt_dir, e.st, e.en, e.clr, e.dir);
          end
        end
      end
      st_prev  = state;
      dir_prev = cnt_dir;
    end
  end

  // Wait until just after rising edge c.
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic [1:0] st, input logic en,
                           input logic clr, input logic dir);
    ev_t e;
    e.cyc = c; e.st = st; e.en = en; e.clr = clr; e.dir = dir;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic press_run(input int c);
    at(c);     btn_run = 1'b1;
    at(c + 6); btn_run = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for edges 1..3.
    at(3);
    reset = 1'b0;
    chk("reset_state",   int'(state),   0);
    chk("reset_cnt_en",  int'(cnt_en),  0);
    chk("reset_cnt_clr", int'(cnt_clr), 0);
    chk("reset_cnt_dir", int'(cnt_dir), 1);
    st_prev  = 2'd0;
    dir_prev = 1'b1;
    mon_on   = 1'b1;

    // The synchronizers restart at 0, so IDLE briefly copies sw_ud=0
    // (edges 4,5) before the synced 1 arrives at edge 6.
    expect_ev(4, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_ev(6, 2'd0, 1'b0, 1'b0, 1'b1);

    // Bounce rejection: toggling every 2 cycles, then a 3-cycle glitch.
    for (int i = 0; i < 10; i++) begin
      at(8 + 2 * i);
      btn_run = (i % 2 == 0);
    end
    at(32); btn_run = 1'b1;
    at(35); btn_run = 1'b0;
    at(45);
    chk("bounce_idle", int'(state), 0);

`ifdef LED_SEQ_BOUNCE_EN
    // Ping-pong: FC->FD@69, FD->FE@79, FE->FF@89, TURN@90, skip, RUN down@99.
    expect_ev(58, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_ev(69, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(79, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(89, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(90, 2'd3, 1'b0, 1'b0, 1'b1);
    expect_ev(99, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_ev(109, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ev(119, 2'd1, 1'b1, 1'b0, 1'b0);
    at(50); btn_run = 1'b1;
    at(70); btn_run = 1'b0;
    at(121);
    mon_on = 1'b0;
    chk("bounce_final_val", int'(model_cnt), 8'hFD);
    chk("bounce_no_wrap",   int'(wrapped),   0);
`else
    // Run press at 50 -> RUN at 58; slow ticks give cnt_en at 69, 79, 89.
    expect_ev(58, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_ev(69, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(79, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(89, 2'd1, 1'b1, 1'b0, 1'b1);
    // sw_sf synced at 95 while the divider holds 7 -> wrap 96, then fast.
    expect_ev(97,  2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(101, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(105, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(109, 2'd1, 1'b1, 1'b0, 1'b1);
    // sw_ud=0 synced at 109 -> TURN at 110, wrap 112 skipped, RUN down at 113.
    expect_ev(110, 2'd3, 1'b0, 1'b0, 1'b1);
    expect_ev(113, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_ev(117, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ev(121, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ev(125, 2'd1, 1'b1, 1'b0, 1'b0);
    // Both buttons at 121: clear wins at 129 and suppresses that step.
    expect_ev(129, 2'd0, 1'b0, 1'b1, 1'b0);
    // Run press at 140 -> RUN at 148; fast steps at 153, 157, 161.
    expect_ev(148, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_ev(153, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ev(157, 2'd1, 1'b1, 1'b0, 1'b0);
    expect_ev(161, 2'd1, 1'b1, 1'b0, 1'b0);
    // Run press at 155 -> PAUSE at 163; PAUSE follows sw_ud=1 at 168.
    expect_ev(163, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_ev(168, 2'd2, 1'b0, 1'b0, 1'b1);
    // Run press at 175 -> RUN at 183; first step L+1 = 5 cycles later.
    expect_ev(183, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_ev(188, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(192, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_ev(196, 2'd1, 1'b1, 1'b0, 1'b1);

    at(50);  btn_run = 1'b1;
    at(70);  btn_run = 1'b0;
    at(93);  sw_sf   = 1'b1;
    at(107); sw_ud   = 1'b0;
    at(121); btn_run = 1'b1; btn_clr = 1'b1;
    at(127); btn_run = 1'b0; btn_clr = 1'b0;
    press_run(140);
    press_run(155);
    at(165); sw_ud = 1'b1;
    press_run(175);
    at(198);
    mon_on = 1'b0;
`endif

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_event @%0d: got no event, required st=%0d en=%0b clr=%0b dir=%0b",
               e.cyc, e.st, e.en, e.clr, e.dir);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the 8-bit LED counter datapath. It debounces the run and clear pushbuttons, synchronizes the speed and direction switches, and owns the tick divider. A run/pause/turn state machine drives the counter's enable, direction and clear strobes. It sits between the board I/O and the LED counter register, both on the buffered `sys_clk` domain.

## Interface
- `DEB_CYCLES`, default 2_000_000: cycles a synchronized button must be stable before its debounced level updates (10 ms at 200 MHz).
- `SLOW_DIV`, default 100_000_000: tick period in cycles when `sw_sf`=0.
- `FAST_DIV`, default 20_000_000: tick period in cycles when `sw_sf`=1.
- `sys_clk`, input, 1: system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_run`, input, 1: raw pushbutton; each press toggles run/pause.
- `btn_clr`, input, 1: raw pushbutton; a press clears the counter and goes to IDLE.
- `sw_ud`, input, 1: requested direction (1 = up).
- `sw_sf`, input, 1: speed select (1 = fast).
- `cnt_val`, input, 8: current counter value (feedback; used only with the macro).
- `cnt_en`, output, 1: one-cycle step strobe to the counter.
- `cnt_dir`, output, 1: applied direction (1 = up).
- `cnt_clr`, output, 1: one-cycle clear strobe to the counter.
- `state`, output, 2: FSM state (IDLE=0, RUN=1, PAUSE=2, TURN=3).

## Operation
- **Inputs:** all four inputs pass through 2-flop synchronizers. The buttons then go through a debounce counter, which restarts on any change of the synchronized level. When the counter reaches `DEB_CYCLES`, the debounced level is updated. A rising edge of the debounced level produces a one-cycle `press` pulse. Releases produce no pulse.
- **Tick divider (28-bit):**
  - Counts only in RUN and TURN; it is forced to 0 in IDLE and PAUSE.
  - Limit `L` = `sw_sf` ? `FAST_DIV` : `SLOW_DIV`.
  - When count ≥ `L`−1, the count wraps to 0 and `wrap` pulses for one cycle. Otherwise the count increments.
  - The ≥ compare makes a fast→slow→fast switch mid-period wrap on the next cycle.
- **FSM:**
  - IDLE → RUN on run press.
  - RUN → PAUSE on run press.
  - PAUSE → RUN on run press. The divider restarts at 0, giving a full period before the first step.
  - RUN → TURN when the synced `sw_ud` ≠ `cnt_dir`.
  - TURN → RUN on `wrap`, with `cnt_dir` ← synced `sw_ud`. No step is issued on that wrap: one skipped period marks the reversal.
  - TURN → PAUSE on run press, with `cnt_dir` updated in the same cycle.
  - If `sw_ud` returns to equal `cnt_dir` while in TURN, the FSM still waits for `wrap` and then goes to RUN (no direction change).
  - Any state → IDLE on clear press, with `cnt_clr`=1 for that one cycle.
  - In IDLE and PAUSE, `cnt_dir` follows the synced `sw_ud` every cycle.
- **Counter strobe:** `cnt_en` = registered (`state`==RUN && `wrap`). It is never asserted in the same cycle as `cnt_clr`.
- **Simultaneous presses:** clear has priority over run. A run press in the clear cycle is dropped.

## Timing
- **Reset values (cycle after `reset`=1 is sampled):**
  - `state`=IDLE, `cnt_en`=0, `cnt_clr`=0, `cnt_dir`=1.
  - Divider, debounce counters, synchronizers and debounced levels are all 0.
- **Reset mid-operation:** same as above. Any pending TURN or debounce is discarded.
- **Button latency:** a raw edge held stable produces `press` exactly `DEB_CYCLES`+3 cycles later (2 sync + `DEB_CYCLES` + 1 edge detect). The state changes the cycle after `press`.
- **Clear latency:** `cnt_clr` is high in the cycle the FSM enters IDLE.
- **Step latency:** `cnt_en` is high one cycle after `wrap`. From PAUSE→RUN, the first `cnt_en` comes `L`+1 cycles after the state change.
- **Switch latency:** `sw_ud` and `sw_sf` take effect 2 cycles after they change.

## Configuration
- **`LED_SEQ_BOUNCE_EN` defined:** ping-pong mode.
  - In RUN, when `cnt_en` fires with `cnt_val`==8'hFE and `cnt_dir`=1, the FSM enters TURN. The same applies for `cnt_val`==8'h01 with `cnt_dir`=0.
  - On leaving TURN, `cnt_dir` inverts and `sw_ud` is ignored.
  - The counter therefore peaks at 8'hFF or 8'h00, holds for one skipped period, then reverses. It never wraps.
- **Undefined:** `cnt_val` is unused, the counter wraps 8'hFF↔8'h00 freely, and direction comes only from `sw_ud`.

## Test plan
All scenarios use `DEB_CYCLES`=4, `SLOW_DIV`=10, `FAST_DIV`=4.
- **Reset:** assert `reset` for 3 cycles → `state`=0, `cnt_en`=`cnt_clr`=0, `cnt_dir`=1. Then hold `btn_run` high 20 cycles → `state`=1 at cycle 8 after the edge. `cnt_en` pulses every 10 cycles.
- **Bounce rejection:** toggle `btn_run` every 2 cycles for 20 cycles, then settle low → no press and `state` stays IDLE. Then a 3-cycle glitch → still no press.
- **Speed switch:** in RUN with `sw_sf`=0, set `sw_sf`=1 at divider count 7 → `wrap` on the next cycle, then `cnt_en` every 4 cycles.
- **Direction change:** in RUN `cnt_dir`=1, drive `sw_ud`=0 → `state`=3, exactly one wrap with no `cnt_en`, then `state`=1 and `cnt_dir`=0.
- **Simultaneous presses:** `btn_run` and `btn_clr` pressed together from RUN → `cnt_clr` one cycle, `state`=IDLE, `cnt_en`=0. A later run press → RUN.
- **Bounce mode:** with `LED_SEQ_BOUNCE_EN`, feed `cnt_val` from a model counter starting at 8'hFC going up → values run FC, FD, FE, FF, hold one period, then FE, FD. `cnt_val` never equals 00 after FF.
